// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: the sequencer state encoding, the retry counter width, and the
// width calculation for the single shared down-counter.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } seq_state_t;

   localparam int RETRY_W = 4;

   // One extra bit over $clog2 so the largest interval fits as a count.
   function automatic int cnt_width(input int rst_pulse, input int lock_stable,
                                    input int lock_timeout);
      int m;
      m = rst_pulse;
      if (lock_stable > m)  m = lock_stable;
      if (lock_timeout > m) m = lock_timeout;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
// Latency: DEPTH clk cycles from d to q.
// Backpressure: none; d is sampled every cycle.
//
// Ports: clk (destination clock), rst (async, active-high, clears the chain),
//        d (asynchronous input), q (synchronised output).
module sync_2ff #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[DEPTH-2:0], d};
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for stable lock, releases sys_rst, retries on failure.
// Latency: pll_locked reaches the FSM after 2 refclk cycles; all outputs are registered off next-state.
// Backpressure: none; force_relock is a single-cycle request acted on the cycle it is seen.
//
// Ports: refclk (only clock), rst (async active-high), pll_locked (async lock in),
//        force_relock (re-sequence request), pll_rst / sys_rst (active-high resets out),
//        ready (RUN), fail (sticky FAIL), retry_count (failed attempts since last lock).
// Optional macro PLL_SEQ_LOSS_CNT_EN adds loss_count[7:0]: saturating count of
// RUN exits caused by lock loss.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 500000,
   parameter int MAX_RETRIES         = 3
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               force_relock,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_count
`ifdef PLL_SEQ_LOSS_CNT_EN
   ,
   output logic [7:0]         loss_count
`endif
);

   localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] RP_LD  = CW'(RST_PULSE_CYCLES);
   localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT_CYCLES);
   // The WAIT_LOCK cycle that first sees lock counts as the first locked cycle.
   localparam logic [CW-1:0] SC_LD  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   seq_state_t         state, nxt_state;
   logic [CW-1:0]      cnt, nxt_cnt, remaining;
   logic [RETRY_W-1:0] nxt_retry;
   logic               lock_s;
   logic               enter;
   logic               expired;

   sync_2ff #(.DEPTH(2)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   // cnt holds the cycles left in the current state, including this one.
   // It is zero only straight after rst (treated as a fresh full reset
   // pulse) or for a one-cycle stabilise window.
   always_comb begin
      nxt_state = state;
      nxt_retry = retry_count;
      nxt_cnt   = '0;
      enter     = 1'b0;
      remaining = (cnt != '0) ? cnt : ((state == RESET_PLL) ? RP_LD : ONE);
      expired   = (remaining == ONE);

      case (state)
         RESET_PLL: begin
            if (force_relock) begin
               enter = 1'b1;
            end else if (expired) begin
               nxt_state = WAIT_LOCK;
               enter     = 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (force_relock) begin
               nxt_state = RESET_PLL;
               enter     = 1'b1;
            end else if (lock_s) begin
               nxt_state = STABILIZE;
               enter     = 1'b1;
            end else if (expired) begin
               nxt_retry = retry_count + RETRY_W'(1);
               nxt_state = (nxt_retry == RETRY_W'(MAX_RETRIES)) ? FAIL : RESET_PLL;
               enter     = 1'b1;
            end
         end
         STABILIZE: begin
            if (force_relock) begin
               nxt_state = RESET_PLL;
               enter     = 1'b1;
            end else if (!lock_s) begin
               nxt_state = WAIT_LOCK;
               enter     = 1'b1;
            end else if (expired) begin
               nxt_state = RUN;
               nxt_retry = '0;
               enter     = 1'b1;
            end
         end
         RUN: begin
            // Lock loss and force_relock together still make one transition.
            if (force_relock || !lock_s) begin
               nxt_state = RESET_PLL;
               enter     = 1'b1;
            end
         end
         FAIL: begin
            nxt_state = FAIL;
         end
         default: begin
            nxt_state = RESET_PLL;
            enter     = 1'b1;
         end
      endcase

      if (enter) begin
         case (nxt_state)
            RESET_PLL: nxt_cnt = RP_LD;
            WAIT_LOCK: nxt_cnt = TO_LD;
            STABILIZE: nxt_cnt = SC_LD;
            default:   nxt_cnt = '0;
         endcase
      end else begin
         nxt_cnt = remaining - ONE;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state       <= RESET_PLL;
         cnt         <= '0;
         retry_count <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         fail        <= 1'b0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         retry_count <= nxt_retry;
         pll_rst     <= (nxt_state == RESET_PLL) || (nxt_state == FAIL);
         sys_rst     <= (nxt_state != RUN);
         ready       <= (nxt_state == RUN);
         fail        <= (nxt_state == FAIL);
      end
   end

`ifdef PLL_SEQ_LOSS_CNT_EN
   // In RUN, a low lock_s always causes the exit, with or without force_relock.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         loss_count <= '0;
      end else if (state == RUN && !lock_s && loss_count != 8'hFF) begin
         loss_count <= loss_count + 8'd1;
      end
   end
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the reset and lock sequence of the single-output core PLL (50 MHz refclk in, 40 MHz out).
- Pulses the PLL reset, waits for lock with a timeout, and requires lock to stay stable before releasing the downstream system reset.
- Re-sequences the PLL on lock loss or on a software request, with bounded retries.
- Runs entirely in the always-on refclk domain; consumers in the PLL output domain resynchronise sys_rst themselves.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 500000, cycles in WAIT_LOCK before the attempt is declared failed (10 ms at 50 MHz)
MAX_RETRIES, 3, failed attempts allowed before entering FAIL (1..15)

Ports:
refclk  input  1  free-running 50 MHz reference clock; the block's only clock
rst  input  1  asynchronous, active-high reset
pll_locked  input  1  PLL lock output, asynchronous to refclk
force_relock  input  1  single-cycle request to re-sequence the PLL
pll_rst  output  1  reset to the PLL, active-high
sys_rst  output  1  downstream system reset, active-high
ready  output  1  high only in RUN
fail  output  1  high only in FAIL (sticky until rst)
retry_count  output  4  failed attempts since the last successful lock

Behaviour:
- Reset is asynchronous and active-high on rst; refclk is the only clock.
- pll_locked passes through a 2-flop synchroniser (lock_s) before any use; this adds 2 cycles of detection latency.
- Values while rst is high: state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_count=0, counters=0.
- A single down-counter, width $clog2 of the largest parameter + 1, is shared by all timed states and reloaded on every state entry.
- RESET_PLL:
  - Outputs: pll_rst=1, sys_rst=1.
  - After exactly RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK:
  - Outputs: pll_rst=0, sys_rst=1.
  - If lock_s=1, go to STABILIZE.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles, increment retry_count. If the new count equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
- STABILIZE:
  - Outputs: pll_rst=0, sys_rst=1.
  - If lock_s drops, go back to WAIT_LOCK. The timeout restarts; retry_count is unchanged.
  - After LOCK_STABLE_CYCLES consecutive cycles of lock_s=1, go to RUN and clear retry_count.
- RUN:
  - Outputs: pll_rst=0, sys_rst=0, ready=1.
  - If lock_s=0 for one cycle, or force_relock=1, go to RESET_PLL. sys_rst rises on the cycle after detection (registered output).
  - Lock loss in RUN does not increment retry_count.
- FAIL:
  - Outputs: pll_rst=1, sys_rst=1, fail=1.
  - Terminal state; only rst exits it. force_relock is ignored here.
- force_relock in states other than RUN and FAIL: restart at RESET_PLL, keeping retry_count.
- Simultaneous events: force_relock and lock loss in the same cycle in RUN give a single transition to RESET_PLL.
- All outputs are registered and decoded from next-state, so they change on the same edge as the state.
- Asserting rst mid-sequence aborts immediately to the reset values; there is no partial-state retention.

Optional Feature:
PLL_SEQ_LOSS_CNT_EN
- Defined: adds output port loss_count [7:0].
  - Saturating count of RUN->RESET_PLL transitions caused by lock loss (force_relock is not counted).
  - Cleared only by rst; holds at 255.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum (RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL; 3-bit encoding);
  - the retry_count width constant;
  - a function computing the counter width from the parameters.
- Sub-module sync_2ff: 1-bit, parameterised-depth synchroniser with asynchronous active-high reset; instantiated once for pll_locked.

Test Plan (sim parameters RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20, MAX_RETRIES=3):
- Nominal: release rst, assert pll_locked 10 cycles later -> pll_rst high exactly 4 cycles; sys_rst falls 8+2 cycles after pll_locked rises; ready=1; retry_count=0.
- Timeout/fail: pll_locked held 0 -> three 4-high/20-low pll_rst cycles; retry_count steps 1,2,3; fail=1 and pll_rst=1 thereafter; force_relock has no effect.
- Glitch in STABILIZE: drop pll_locked for 1 cycle after 5 stable cycles -> stays in sys_rst=1; full 8-cycle stabilisation restarts; retry_count unchanged.
- Lock loss in RUN: drop pll_locked -> sys_rst=1 within 3 cycles; new 4-cycle pll_rst pulse; re-locks to ready=1; with PLL_SEQ_LOSS_CNT_EN defined, loss_count=1.
- force_relock in RUN plus a retry recovery: one timeout then lock -> retry_count 1 then cleared to 0 on RUN; a force_relock pulse -> pll_rst pulse; loss_count not incremented.
- Reset mid-operation: assert rst during WAIT_LOCK and during RUN -> all outputs take their reset values asynchronously, before the next refclk edge.
